ram_arbiter: RTL and testbench

- Round-robin arbiter sharing the single RAM port among NREQ word-level requesters: icache0, icache1, dcache0 and dcache1 in the default build.
- Sits between the cache-side bus logic and the RAM model.
- Owns the grant, the handshake, and line-burst locking with a starvation bound.
- Coherence sequencing stays upstream; this block only serialises RAM accesses.

---
 rtl/cpu_types_pkg.sv | 6 +
 rtl/rr_picker.sv | 26 ++
 rtl/ram_arbiter.sv | 114 +++++++++++
 tb/tb_ram_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM word/state encodings plus the RAM arbiter FSM state.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// First-active search starting at ptr and wrapping mod N; N need not be a power of 2.
module rr_picker #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  active,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);
  int j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && active[IW'(j)]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin owner of the single RAM port; serialises word accesses with bounded burst locking.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int LOCK_MAX = 2,
  localparam int IW       = $clog2(NREQ)
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [NREQ-1:0]         req_ren,
  input  logic [NREQ-1:0]         req_wen,
  input  logic [NREQ-1:0]         req_lock,
  input  word_t [NREQ-1:0]        req_addr,
  input  word_t [NREQ-1:0]        req_store,
  output logic [NREQ-1:0]         req_wait,
  output word_t [NREQ-1:0]        req_load,
  output logic                    ramREN,
  output logic                    ramWEN,
  output word_t                   ramaddr,
  output word_t                   ramstore,
  input  word_t                   ramload,
  input  ramstate_t               ramstate,
  output logic                    grant_valid,
  output logic [IW-1:0]           grant_id,
  output logic                    err
);
  localparam int LW = $clog2(LOCK_MAX + 1);

  arb_state_t    state, nxt_state;
  logic [IW-1:0] owner, nxt_owner, rr_ptr, nxt_ptr, owner_inc, pick_idx;
  logic [LW-1:0] lock_cnt, nxt_lock;
  logic          pick_found, owner_act;

  rr_picker #(.N(NREQ)) u_pick (
    .active (req_ren | req_wen),
    .ptr    (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  assign owner_act = req_ren[owner] | req_wen[owner];
  assign owner_inc = (int'(owner) == NREQ - 1) ? '0 : owner + IW'(1);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= nxt_state;
      owner    <= nxt_owner;
      rr_ptr   <= nxt_ptr;
      lock_cnt <= nxt_lock;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_owner = owner;
    nxt_ptr   = rr_ptr;
    nxt_lock  = lock_cnt;
    case (state)
      IDLE: if (pick_found) begin
        nxt_state = GRANT;
        nxt_owner = pick_idx;
        nxt_lock  = '0;
      end
      GRANT: begin
        // Withdrawal and ERROR both release without completing; the requester retries later.
        if (!owner_act || ramstate == ERROR) begin
          nxt_state = IDLE;
          nxt_ptr   = owner_inc;
        end else if (ramstate == ACCESS) begin
          if (req_lock[owner] && (int'(lock_cnt) + 1 < LOCK_MAX))
            nxt_lock = lock_cnt + LW'(1);
          else begin
            nxt_state = IDLE;
            nxt_ptr   = owner_inc;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    err      = 1'b0;
    if (state == GRANT) begin
      ramaddr = req_addr[owner];
      if (req_wen[owner]) begin
        ramWEN   = 1'b1;
        ramstore = req_store[owner];
      end else
        ramREN = req_ren[owner];
      err = owner_act && (ramstate == ERROR);
    end
  end

  assign grant_valid = (state == GRANT);
  assign grant_id    = owner;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    logic done;
    assign done        = (state == GRANT) && (owner == IW'(i)) && owner_act && (ramstate == ACCESS);
    assign req_wait[i] = ~done;
    assign req_load[i] = done ? ramload : '0;
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: read, rotation, write priority, lock bound, error, withdrawal, reset.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [3:0]  req_ren, req_wen, req_lock, req_wait;
  word_t [3:0] req_addr, req_store, req_load;
  logic        ramREN, ramWEN;
  word_t       ramaddr, ramstore, ramload;
  ramstate_t   ramstate;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  ram_arbiter #(.NREQ(4), .LOCK_MAX(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_ren(req_ren), .req_wen(req_wen), .req_lock(req_lock),
    .req_addr(req_addr), .req_store(req_store),
    .req_wait(req_wait), .req_load(req_load),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .grant_valid(grant_valid), .grant_id(grant_id), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         rr_exp [5] = '{3, 0, 1, 2, 3};
    logic [3:0] w;

    nRST      = 1'b0;
    req_ren   = '0;
    req_wen   = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_store = '0;
    req_addr[0] = 32'h100;
    req_addr[1] = 32'h80;
    req_addr[2] = 32'h40;
    req_addr[3] = 32'h300;
    ramload   = '0;
    ramstate  = FREE;
    #3;
    chk("rst_ren", ramREN, 0);
    chk("rst_wen", ramWEN, 0);
    chk("rst_addr", ramaddr, 0);
    chk("rst_store", ramstore, 0);
    chk("rst_wait", req_wait, 4'hF);
    chk("rst_load2", req_load[2], 0);
    chk("rst_gv", grant_valid, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_err", err, 0);
    #5 nRST = 1'b1;

    // single read from requester 2, two BUSY cycles then ACCESS
    cyc; req_ren = 4'b0100; ramstate = BUSY; #1;
    chk("rd_idle_ren", ramREN, 0);
    chk("rd_idle_gv", grant_valid, 0);
    cyc; #1;
    chk("rd_ren", ramREN, 1);
    chk("rd_addr", ramaddr, 32'h40);
    chk("rd_gid", grant_id, 2);
    chk("rd_busy_wait", req_wait, 4'hF);
    cyc; #1;
    chk("rd_busy2_wait", req_wait, 4'hF);
    cyc; ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    chk("rd_done_wait", req_wait, 4'b1011);
    chk("rd_load2", req_load[2], 32'hDEADBEEF);
    chk("rd_load1", req_load[1], 0);
    cyc; req_ren = '0; #1;
    chk("rd_rel_gv", grant_valid, 0);
    chk("rd_rel_ren", ramREN, 0);

    // rotation, pointer left at 3 by the read
    req_ren = 4'hF;
    for (int k = 0; k < 5; k++) begin
      cyc; #1;
      w = 4'hF;
      w[rr_exp[k]] = 1'b0;
      chk("rr_gv", grant_valid, 1);
      chk("rr_gid", grant_id, rr_exp[k]);
      chk("rr_wait", req_wait, w);
      cyc; #1;
      chk("rr_idle_gv", grant_valid, 0);
    end
    req_ren = '0;

    // write beats read on the same requester
    req_ren = 4'b0010; req_wen = 4'b0010; req_store[1] = 32'h12345678; ramstate = BUSY;
    cyc; #1;
    chk("wr_wen", ramWEN, 1);
    chk("wr_ren", ramREN, 0);
    chk("wr_store", ramstore, 32'h12345678);
    chk("wr_addr", ramaddr, 32'h80);
    chk("wr_gid", grant_id, 1);
    ramstate = ACCESS; #1;
    chk("wr_wait", req_wait, 4'b1101);
    cyc; req_ren = '0; req_wen = '0; #1;
    chk("wr_rel_gv", grant_valid, 0);

    // lock capped at two words, then 3 gets the port
    req_ren = 4'b0001; req_lock = 4'b0001; ramstate = ACCESS;
    cyc; req_ren = 4'b1001; #1;
    chk("lk_w1_gid", grant_id, 0);
    chk("lk_w1_wait", req_wait, 4'b1110);
    cyc; #1;
    chk("lk_w2_gv", grant_valid, 1);
    chk("lk_w2_gid", grant_id, 0);
    chk("lk_w2_wait", req_wait, 4'b1110);
    cyc; #1;
    chk("lk_rel_gv", grant_valid, 0);
    cyc; #1;
    chk("lk_next_gid", grant_id, 3);
    chk("lk_next_addr", ramaddr, 32'h300);
    chk("lk_next_wait", req_wait, 4'b0111);
    cyc; req_ren = '0; req_lock = '0; #1;
    chk("lk_end_gv", grant_valid, 0);

    // ERROR on owner 1, retry after 2 is served
    req_ren = 4'b0010; ramstate = ERROR;
    cyc; #1;
    chk("er_err", err, 1);
    chk("er_wait", req_wait, 4'hF);
    chk("er_gid", grant_id, 1);
    cyc; req_ren = 4'b0110; ramstate = ACCESS; #1;
    chk("er_err_low", err, 0);
    chk("er_rel_gv", grant_valid, 0);
    cyc; #1;
    chk("er_other_gid", grant_id, 2);
    cyc; req_ren = 4'b0010; #1;
    chk("er_idle_gv", grant_valid, 0);
    cyc; #1;
    chk("er_retry_gid", grant_id, 1);
    chk("er_retry_wait", req_wait, 4'b1101);
    chk("er_retry_err", err, 0);
    cyc; req_ren = '0; #1;

    // owner withdraws mid-grant
    req_ren = 4'b0001; ramstate = BUSY;
    cyc; #1;
    chk("wd_gid", grant_id, 0);
    chk("wd_ren", ramREN, 1);
    cyc; req_ren = '0; #1;
    chk("wd_drop_gv", grant_valid, 1);
    chk("wd_drop_ren", ramREN, 0);
    chk("wd_drop_err", err, 0);
    cyc; req_ren = 4'b1001; #1;
    chk("wd_rel_gv", grant_valid, 0);
    chk("wd_rel_err", err, 0);

    // reset while owner 3 is mid-access
    cyc; #1;
    chk("rs_pre_gid", grant_id, 3);
    chk("rs_pre_ren", ramREN, 1);
    nRST = 1'b0; #1;
    chk("rs_ren", ramREN, 0);
    chk("rs_wen", ramWEN, 0);
    chk("rs_gv", grant_valid, 0);
    chk("rs_wait", req_wait, 4'hF);
    chk("rs_gid", grant_id, 0);
    #1 nRST = 1'b1;
    cyc; #1;
    chk("rs_first_gv", grant_valid, 1);
    chk("rs_first_gid", grant_id, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
